// File: rtl/aes_pkg.sv
// Shared AES decipher definitions: key-length codes, round counts, FSM states
// and the GF(2^8) / inverse-round helpers used by the iterative datapath.
package aes_pkg;

  localparam logic [1:0] KEYLEN_128 = 2'b00;
  localparam logic [1:0] KEYLEN_192 = 2'b01;
  localparam logic [1:0] KEYLEN_256 = 2'b10;

  localparam logic [3:0] NR_128 = 4'd10;
  localparam logic [3:0] NR_192 = 4'd12;
  localparam logic [3:0] NR_256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_SBOX = 2'd2,
    ST_MAIN = 2'd3
  } state_t;

  function automatic logic [3:0] nr_of(input logic [1:0] kl);
    logic [3:0] nr;
    case (kl)
      KEYLEN_192: nr = NR_192;
      KEYLEN_256: nr = NR_256;
      default:    nr = NR_128;
    endcase
    return nr;
  endfunction

  function automatic logic [7:0] gm2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm4(input logic [7:0] b);
    return gm2(gm2(b));
  endfunction

  function automatic logic [7:0] gm8(input logic [7:0] b);
    return gm2(gm4(b));
  endfunction

  function automatic logic [7:0] gm9(input logic [7:0] b);
    return gm8(b) ^ b;
  endfunction

  function automatic logic [7:0] gm11(input logic [7:0] b);
    return gm8(b) ^ gm2(b) ^ b;
  endfunction

  function automatic logic [7:0] gm13(input logic [7:0] b);
    return gm8(b) ^ gm4(b) ^ b;
  endfunction

  function automatic logic [7:0] gm14(input logic [7:0] b);
    return gm8(b) ^ gm4(b) ^ gm2(b);
  endfunction

  function automatic logic [31:0] inv_mixw(input logic [31:0] w);
    logic [7:0] b0, b1, b2, b3;
    b0 = w[31:24];
    b1 = w[23:16];
    b2 = w[15:8];
    b3 = w[7:0];
    return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3),
            gm9(b0)  ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
            gm13(b0) ^ gm9(b1)  ^ gm14(b2) ^ gm11(b3),
            gm11(b0) ^ gm13(b1) ^ gm9(b2)  ^ gm14(b3)};
  endfunction

  function automatic logic [127:0] inv_mixcolumns(input logic [127:0] d);
    return {inv_mixw(d[127:96]), inv_mixw(d[95:64]),
            inv_mixw(d[63:32]),  inv_mixw(d[31:0])};
  endfunction

  // Byte (col c, row r) lives at bits 127-8*(4c+r); row r rotates right by r.
  function automatic logic [127:0] inv_shiftrows(input logic [127:0] d);
    logic [127:0] o;
    o = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127 - 8*(4*c + r) -: 8] = d[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Four-byte inverse S-box: inverse affine map followed by the GF(2^8)
// multiplicative inverse (x^254), so no lookup table is needed.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = gm2(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] e;
    r = 8'h01;
    e = 8'hfe;
    for (int i = 7; i >= 0; i--) begin
      r = gf_mul(r, r);
      r = e[i] ? gf_mul(r, x) : r;
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] a;
    a = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return gf_inv(a);
  endfunction

  assign o_word = {inv_sbox(i_word[31:24]), inv_sbox(i_word[23:16]),
                   inv_sbox(i_word[15:8]),  inv_sbox(i_word[7:0])};

endmodule

// File: rtl/aes_decipher_core_p.sv
// Iterative AES-128/192/256 inverse cipher with a configurable number of
// inverse-S-box lanes, abort, done pulse and illegal-keylen error pulse.
module aes_decipher_core_p
  import aes_pkg::*;
#(
  parameter int SBOX_LANES  = 1,
  parameter bit SUPPORT_192 = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         next,
  input  logic         abort,
  input  logic [1:0]   keylen,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  input  logic [127:0] block,
  output logic [127:0] new_block,
  output logic         ready,
  output logic         valid,
  output logic         error
);

  localparam int         S         = 4 / SBOX_LANES;
  localparam int         LW        = 32 * SBOX_LANES;
  localparam logic [1:0] LANE_LAST = 2'(S - 1);

  state_t         r_state, w_state_nxt;
  logic [127:0]   r_new_block, w_new_block_nxt;
  logic [3:0]     r_round, w_round_nxt;
  logic [1:0]     r_lane, w_lane_nxt;
  logic [1:0]     r_keylen, w_keylen_nxt;
  logic           r_ready, w_ready_nxt;
  logic           r_valid, w_valid_nxt;
  logic           r_error, w_error_nxt;
  logic           w_keylen_ok;
  logic [6:0]     w_lane_hi;
  logic [LW-1:0]  w_sbox_in, w_sbox_out;

  assign w_keylen_ok = (keylen == KEYLEN_128) || (keylen == KEYLEN_256) ||
                       ((keylen == KEYLEN_192) && SUPPORT_192);
  assign w_lane_hi   = 7'(127 - LW * int'(r_lane));
  assign w_sbox_in   = r_new_block[w_lane_hi -: LW];

  for (genvar g = 0; g < SBOX_LANES; g++) begin : g_sbox
    aes_inv_sbox u_inv_sbox (
      .i_word (w_sbox_in[32*g +: 32]),
      .o_word (w_sbox_out[32*g +: 32])
    );
  end

  // Next-state and datapath update; abort overrides everything outside IDLE.
  always_comb begin
    w_state_nxt     = r_state;
    w_new_block_nxt = r_new_block;
    w_round_nxt     = r_round;
    w_lane_nxt      = r_lane;
    w_keylen_nxt    = r_keylen;
    w_ready_nxt     = r_ready;
    w_valid_nxt     = 1'b0;
    w_error_nxt     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (next && w_keylen_ok) begin
          w_keylen_nxt = keylen;
          w_round_nxt  = nr_of(keylen);
          w_ready_nxt  = 1'b0;
          w_state_nxt  = ST_INIT;
        end else if (next) begin
          w_error_nxt = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_INIT: begin
        w_new_block_nxt = inv_shiftrows(block ^ round_key);
        w_round_nxt     = nr_of(r_keylen);
        w_lane_nxt      = 2'd0;
        w_state_nxt     = ST_SBOX;
      end
      ST_SBOX: begin
        w_new_block_nxt[w_lane_hi -: LW] = w_sbox_out;
        if (r_lane == LANE_LAST) begin
          w_lane_nxt  = 2'd0;
          w_round_nxt = r_round - 4'd1;
          w_state_nxt = ST_MAIN;
        end else begin
          w_lane_nxt = r_lane + 2'd1;
        end
      end
      ST_MAIN: begin
        if (r_round != 4'd0) begin
          w_new_block_nxt = inv_shiftrows(inv_mixcolumns(r_new_block ^ round_key));
          w_state_nxt     = ST_SBOX;
        end else begin
          w_new_block_nxt = r_new_block ^ round_key;
          w_ready_nxt     = 1'b1;
          w_valid_nxt     = 1'b1;
          w_state_nxt     = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    if (abort && (r_state != ST_IDLE)) begin
      w_state_nxt     = ST_IDLE;
      w_new_block_nxt = 128'h0;
      w_round_nxt     = 4'd0;
      w_lane_nxt      = 2'd0;
      w_ready_nxt     = 1'b1;
      w_valid_nxt     = 1'b0;
    end else begin
      w_error_nxt = w_error_nxt;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_new_block <= 128'h0;
      r_round     <= 4'd0;
      r_lane      <= 2'd0;
      r_keylen    <= 2'b00;
      r_ready     <= 1'b1;
      r_valid     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_new_block <= w_new_block_nxt;
      r_round     <= w_round_nxt;
      r_lane      <= w_lane_nxt;
      r_keylen    <= w_keylen_nxt;
      r_ready     <= w_ready_nxt;
      r_valid     <= w_valid_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign round     = r_round;
  assign new_block = r_new_block;
  assign ready     = r_ready;
  assign valid     = r_valid;
  assign error     = r_error;

endmodule
